// File: rtl/mmu09_intctl.sv
// MMU09 interrupt controller: synchronised edge-triggered sources latched into PEND,
// masked and routed to IRQ/FIRQ, plus a fixed-width NMI pulse generator with holdoff.
module mmu09_intctl #(
  parameter int NSRC      = 8,
  parameter int NMI_PULSE = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            eclk,
  input  logic            cs_n,
  input  logic            rw,
  input  logic [1:0]      addr,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  output logic            irq_n,
  output logic            firq_n,
  output logic            nmi_n
);

  localparam int CW = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NMI_PULSE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLDOFF} nmi_state_e;

  logic [NSRC-1:0] src_s1_q, src_s1_d, src_s2_q, src_s2_d, src_s3_q, src_s3_d;
  logic            nmi_s1_q, nmi_s1_d, nmi_s2_q, nmi_s2_d, nmi_s3_q, nmi_s3_d;
  logic            eclk_dly_q, eclk_dly_d;
  logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, fsel_q, fsel_d;
  logic            irq_n_q, irq_n_d, firq_n_q, firq_n_d, nmi_n_q, nmi_n_d;
  nmi_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            nmi_latch_q, nmi_latch_d;

  logic [NSRC-1:0] src_edge, irq_act, firq_act;
  logic            nmi_edge, commit;
  logic [7:0]      vec;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_s1_q    <= '0;
      src_s2_q    <= '0;
      src_s3_q    <= '0;
      nmi_s1_q    <= 1'b0;
      nmi_s2_q    <= 1'b0;
      nmi_s3_q    <= 1'b0;
      eclk_dly_q  <= 1'b0;
      pend_q      <= '0;
      mask_q      <= '0;
      fsel_q      <= '0;
      irq_n_q     <= 1'b1;
      firq_n_q    <= 1'b1;
      nmi_n_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      nmi_latch_q <= 1'b0;
    end else begin
      src_s1_q    <= src_s1_d;
      src_s2_q    <= src_s2_d;
      src_s3_q    <= src_s3_d;
      nmi_s1_q    <= nmi_s1_d;
      nmi_s2_q    <= nmi_s2_d;
      nmi_s3_q    <= nmi_s3_d;
      eclk_dly_q  <= eclk_dly_d;
      pend_q      <= pend_d;
      mask_q      <= mask_d;
      fsel_q      <= fsel_d;
      irq_n_q     <= irq_n_d;
      firq_n_q    <= firq_n_d;
      nmi_n_q     <= nmi_n_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nmi_latch_q <= nmi_latch_d;
    end
  end

  // Synchronisers, E-fall commit strobe and register updates; a new edge beats a W1C.
  always_comb begin
    src_s1_d   = src;
    src_s2_d   = src_s1_q;
    src_s3_d   = src_s2_q;
    nmi_s1_d   = nmi_src;
    nmi_s2_d   = nmi_s1_q;
    nmi_s3_d   = nmi_s2_q;
    eclk_dly_d = eclk;
    src_edge   = src_s2_q & ~src_s3_q;
    nmi_edge   = nmi_s2_q & ~nmi_s3_q;
    commit     = eclk_dly_q & ~eclk & ~cs_n & ~rw;
    pend_d     = pend_q;
    mask_d     = mask_q;
    fsel_d     = fsel_q;
    if (commit) begin
      case (addr)
        2'd0:    pend_d = pend_q & ~din[NSRC-1:0];
        2'd1:    mask_d = din[NSRC-1:0];
        2'd2:    fsel_d = din[NSRC-1:0];
        default: ;
      endcase
    end
    pend_d   = pend_d | src_edge;
    irq_act  = pend_q & mask_q & ~fsel_q;
    firq_act = pend_q & mask_q & fsel_q;
    irq_n_d  = ~|irq_act;
    firq_n_d = ~|firq_act;
  end

  always_comb begin
    vec = 8'h80;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (irq_act[i]) vec = {5'd0, 3'(i)};
    end
    dout = '0;
    if (!cs_n && rw) begin
      case (addr)
        2'd0:    dout[NSRC-1:0] = pend_q;
        2'd1:    dout[NSRC-1:0] = mask_q;
        2'd2:    dout[NSRC-1:0] = fsel_q;
        default: dout = vec;
      endcase
    end
  end

  // A latched request at the end of holdoff starts the next pulse directly, keeping the gap exact.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nmi_latch_d = nmi_latch_q;
    case (state_q)
      ST_IDLE: begin
        if (nmi_edge || nmi_latch_q) begin
          state_d     = ST_PULSE;
          cnt_d       = CNT_LOAD;
          nmi_latch_d = 1'b0;
        end
      end
      ST_PULSE: begin
        if (nmi_edge) nmi_latch_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_HOLDOFF;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          if (nmi_edge || nmi_latch_q) begin
            state_d     = ST_PULSE;
            cnt_d       = CNT_LOAD;
            nmi_latch_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (nmi_edge) nmi_latch_d = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    nmi_n_d = (state_d != ST_PULSE);
  end

  assign irq_n  = irq_n_q;
  assign firq_n = firq_n_q;
  assign nmi_n  = nmi_n_q;

endmodule

// File: tb/tb_mmu09_intctl.sv
// Self-checking bench for mmu09_intctl: directed scenarios plus a randomized
// register/source sequence compared against a set-level model of PEND/MASK/FSEL.
module tb_mmu09_intctl;

  localparam int NSRC = 8;
  localparam int P    = 16;

  logic       clk = 1'b0;
  logic       reset_n, eclk, cs_n, rw, nmi_src;
  logic [1:0] addr;
  logic [7:0] din, dout, src;
  logic       irq_n, firq_n, nmi_n;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_pend, m_mask, m_fsel;

  mmu09_intctl #(.NSRC(NSRC), .NMI_PULSE(P)) dut (
    .clk(clk), .reset_n(reset_n), .eclk(eclk), .cs_n(cs_n), .rw(rw),
    .addr(addr), .din(din), .dout(dout), .src(src), .nmi_src(nmi_src),
    .irq_n(irq_n), .firq_n(firq_n), .nmi_n(nmi_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic readReg(input logic [1:0] a, output logic [7:0] v);
    cs_n = 1'b0; rw = 1'b1; addr = a;
    #1 v = dout;
    cs_n = 1'b1;
  endtask

  // Full E cycle: E high then falling; returns just after the committing clk edge.
  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; rw = 1'b0; addr = a; din = d; eclk = 1'b1;
    @(negedge clk);
    eclk = 1'b0;
    @(posedge clk);
    #1 cs_n = 1'b1; rw = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    src = v;
    repeat (2) @(negedge clk);
    src = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [7:0] modelVec(input logic [7:0] p, m, f);
    logic [7:0] act;
    act = p & m & ~f;
    for (int i = 0; i < NSRC; i++)
      if (act[i]) return 8'(i);
    return 8'h80;
  endfunction

  initial begin
    logic [7:0] v;
    logic       tr [80];
    int         rl [8];
    int         nruns, lows;
    int         op;
    logic [7:0] rv;

    reset_n = 1'b0; src = 8'hFF; nmi_src = 1'b0; cs_n = 1'b1; rw = 1'b1;
    addr = 2'd0; din = 8'h00; eclk = 1'b0;

    // Reset state
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rst_irq_n", irq_n, 8'h01);
    checkOutput("rst_firq_n", firq_n, 8'h01);
    checkOutput("rst_nmi_n", nmi_n, 8'h01);
    checkOutput("rst_dout", dout, 8'h00);
    readReg(2'd0, v); checkOutput("rst_pend", v, 8'h00);
    @(negedge clk) src = 8'h00;
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(negedge clk);
    readReg(2'd0, v); checkOutput("post_rst_pend", v, 8'h00);

    // IRQ path with exact latency
    writeReg(2'd1, 8'h05);
    writeReg(2'd2, 8'h00);
    @(negedge clk) src = 8'h04;
    repeat (3) @(posedge clk);
    #1 checkOutput("irq_lat_edge3", irq_n, 8'h01);
    @(posedge clk);
    #1 checkOutput("irq_lat_edge4", irq_n, 8'h00);
    @(negedge clk) src = 8'h00;
    readReg(2'd3, v); checkOutput("vec_src2", v, 8'h02);
    applyStimulus(8'h01);
    readReg(2'd3, v); checkOutput("vec_src0", v, 8'h00);
    writeReg(2'd0, 8'h01);
    readReg(2'd3, v); checkOutput("vec_after_clr0", v, 8'h02);
    writeReg(2'd0, 8'h04);
    checkOutput("irq_at_commit", irq_n, 8'h00);
    @(posedge clk);
    #1 checkOutput("irq_after_commit", irq_n, 8'h01);
    readReg(2'd3, v); checkOutput("vec_none", v, 8'h80);

    // FIRQ routing
    writeReg(2'd1, 8'h80);
    writeReg(2'd2, 8'h80);
    applyStimulus(8'h80);
    checkOutput("firq_low", firq_n, 8'h00);
    checkOutput("firq_irq_high", irq_n, 8'h01);
    readReg(2'd3, v); checkOutput("firq_vec", v, 8'h80);
    readReg(2'd0, v); checkOutput("firq_pend", v, 8'h80);
    writeReg(2'd0, 8'h80);
    @(posedge clk);
    #1 checkOutput("firq_cleared", firq_n, 8'h01);

    // Masked source latches and asserts once unmasked
    writeReg(2'd1, 8'h00);
    applyStimulus(8'h08);
    readReg(2'd0, v); checkOutput("masked_pend", v, 8'h08);
    checkOutput("masked_irq_n", irq_n, 8'h01);
    writeReg(2'd1, 8'h08);
    checkOutput("unmask_at_commit", irq_n, 8'h01);
    @(posedge clk);
    #1 checkOutput("unmask_next_clk", irq_n, 8'h00);
    readReg(2'd3, v); checkOutput("unmask_vec", v, 8'h03);
    writeReg(2'd0, 8'h08);

    // Collision: W1C of bit 1 commits on the edge that latches src[1]
    @(negedge clk) src = 8'h02;
    @(negedge clk);
    cs_n = 1'b0; rw = 1'b0; addr = 2'd0; din = 8'h02; eclk = 1'b1;
    @(negedge clk) eclk = 1'b0;
    @(posedge clk);
    #1 cs_n = 1'b1; rw = 1'b1;
    readReg(2'd0, v); checkOutput("collision_set_wins", v, 8'h02);
    @(negedge clk) src = 8'h00;
    writeReg(2'd0, 8'h02);
    readReg(2'd0, v); checkOutput("collision_then_clear", v, 8'h00);

    // Writes without an E fall and writes to VEC are ignored
    @(negedge clk);
    cs_n = 1'b0; rw = 1'b0; addr = 2'd1; din = 8'hFF; eclk = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; rw = 1'b1;
    readReg(2'd1, v); checkOutput("no_efall_no_write", v, 8'h08);
    writeReg(2'd3, 8'h5A);
    readReg(2'd3, v); checkOutput("vec_readonly", v, 8'h80);

    // Randomized register/source traffic against the model
    writeReg(2'd0, 8'hFF);
    writeReg(2'd1, 8'h00);
    writeReg(2'd2, 8'h00);
    m_pend = 8'h00; m_mask = 8'h00; m_fsel = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("dout_unselected", dout, 8'h00);
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 4));
      rv = 8'($urandom);
      case (op)
        0, 1: begin applyStimulus(rv); m_pend = m_pend | rv; end
        2:    begin writeReg(2'd1, rv); m_mask = rv; end
        3:    begin writeReg(2'd2, rv); m_fsel = rv; end
        default: begin writeReg(2'd0, rv); m_pend = m_pend & ~rv; end
      endcase
      repeat (2) @(negedge clk);
      readReg(2'd0, v); checkOutput("rnd_pend", v, m_pend);
      readReg(2'd1, v); checkOutput("rnd_mask", v, m_mask);
      readReg(2'd2, v); checkOutput("rnd_fsel", v, m_fsel);
      readReg(2'd3, v); checkOutput("rnd_vec", v, modelVec(m_pend, m_mask, m_fsel));
      checkOutput("rnd_irq_n", irq_n, ((m_pend & m_mask & ~m_fsel) == 8'h00) ? 8'h01 : 8'h00);
      checkOutput("rnd_firq_n", firq_n, ((m_pend & m_mask & m_fsel) == 8'h00) ? 8'h01 : 8'h00);
    end

    // NMI: two edges, the second during the first pulse
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == 0 || k == 8) nmi_src = 1'b1;
      if (k == 3 || k == 10) nmi_src = 1'b0;
      @(posedge clk);
      #1 tr[k] = nmi_n;
    end
    for (int i = 0; i < 8; i++) rl[i] = 0;
    nruns = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0 && tr[k] !== tr[k-1]) nruns++;
      if (nruns < 8) rl[nruns]++;
    end
    checkCount("nmi_run_count", nruns + 1, 5);
    checkCount("nmi_start_delay", rl[0], 2);
    checkCount("nmi_pulse1_len", rl[1], P);
    checkCount("nmi_gap_len", rl[2], P);
    checkCount("nmi_pulse2_len", rl[3], P);
    checkOutput("nmi_first_level", tr[0], 8'h01);

    // Reset asserted in the middle of a pulse
    @(negedge clk) nmi_src = 1'b1;
    repeat (6) @(posedge clk);
    #1 checkOutput("nmi_mid_pulse", nmi_n, 8'h00);
    #2 reset_n = 1'b0;
    #1 checkOutput("nmi_async_release", nmi_n, 8'h01);
    checkOutput("rst_mid_irq_n", irq_n, 8'h01);
    readReg(2'd0, v); checkOutput("rst_mid_pend", v, 8'h00);
    readReg(2'd1, v); checkOutput("rst_mid_mask", v, 8'h00);
    nmi_src = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (nmi_n !== 1'b1) lows++;
    end
    checkCount("nmi_latch_lost", lows, 0);

    $display("[TB] done");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
